// File: rtl/regfile_hilo_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hilo_sb_if
// Purpose  : Decode, writeback and multiply/divide signal bundle for regfile_hilo_sb.
// Revision : 1.0
// ============================================================================
interface regfile_hilo_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic [DATA_W-1:0] imm_ext;
    logic              md_start;
    logic              md_done;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic              stall;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport slave (
        input  instruction, instr_valid, wr_en, wr_addr, wr_data,
        input  md_done, md_hi, md_lo,
        output read_data_1, read_data_2, imm_ext, md_start, stall, hi, lo
    );

    modport master (
        output instruction, instr_valid, wr_en, wr_addr, wr_data,
        output md_done, md_hi, md_lo,
        input  read_data_1, read_data_2, imm_ext, md_start, stall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/regfile_hilo_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_hilo_sb
// Purpose  : Register file with write bypass, HI/LO pair and mul/div scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_hilo_sb #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                clock,
    input  logic                reset,
    regfile_hilo_sb_if.slave    bus
);
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mthi  = 6'b010001;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;
    localparam logic [5:0] c_fn_mtlo  = 6'b010011;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    logic [5:0]        opcode, funct;
    logic              is_r, is_md, is_mfhi, is_mflo, is_mthi, is_mtlo, is_hilo;
    logic [ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] rs_arr, rt_arr, rs_val, rt_val;
    logic              md_start_c, stall_c, mf_we;
    logic [DATA_W-1:0] mf_data;
    logic              unused_bits;

    assign opcode  = bus.instruction[31:26];
    assign funct   = bus.instruction[5:0];
    assign is_r    = (opcode == 6'd0);
    assign is_md   = is_r && (funct[5:2] == 4'b0110);
    assign is_mfhi = is_r && (funct == c_fn_mfhi);
    assign is_mthi = is_r && (funct == c_fn_mthi);
    assign is_mflo = is_r && (funct == c_fn_mflo);
    assign is_mtlo = is_r && (funct == c_fn_mtlo);
    assign is_hilo = is_md || is_mfhi || is_mflo || is_mthi || is_mtlo;

    assign rs_idx = bus.instruction[21 +: ADDR_W];
    assign rt_idx = bus.instruction[16 +: ADDR_W];
    assign rd_idx = bus.instruction[11 +: ADDR_W];
    assign unused_bits = ^bus.instruction[10:6];

    // Writeback port is forwarded so decode sees the value being committed this edge.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] idx,
                                              input logic [DATA_W-1:0] arr_val);
        if (idx == '0)
            return '0;
        else if (bus.wr_en && (bus.wr_addr == idx))
            return bus.wr_data;
        else
            return arr_val;
    endfunction

    always_comb begin
        rs_arr = '0;
        rt_arr = '0;
        if (int'(rs_idx) < REG_CNT) rs_arr = regs_q[rs_idx];
        if (int'(rt_idx) < REG_CNT) rt_arr = regs_q[rt_idx];
        rs_val = fwd(rs_idx, rs_arr);
        rt_val = fwd(rt_idx, rt_arr);
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        md_start_c = 1'b0;
        stall_c    = 1'b0;
        mf_we      = 1'b0;
        mf_data    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && is_md) begin
                    md_start_c = 1'b1;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.md_done) begin
                    hi_d    = bus.md_hi;
                    lo_d    = bus.md_lo;
                    state_d = ST_IDLE;
                end
                stall_c = bus.instr_valid && is_hilo;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.instr_valid && !stall_c) begin
            if (is_mthi) hi_d = rs_val;
            if (is_mtlo) lo_d = rs_val;
            if (is_mfhi || is_mflo) begin
                mf_we   = (rd_idx != '0);
                mf_data = is_mfhi ? hi_q : lo_q;
            end
        end
    end

    // The mf* write is applied last so it overrides an older writeback to the same index.
    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en && (bus.wr_addr != '0) && (int'(bus.wr_addr) < REG_CNT))
            regs_d[bus.wr_addr] = bus.wr_data;
        if (mf_we && (int'(rd_idx) < REG_CNT))
            regs_d[rd_idx] = mf_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            regs_q  <= regs_d;
        end
    end

    assign bus.read_data_1 = rs_val;
    assign bus.read_data_2 = rt_val;
    assign bus.imm_ext     = ((opcode == c_op_andi) || (opcode == c_op_ori) || (opcode == c_op_xori))
                             ? DATA_W'(bus.instruction[15:0])
                             : DATA_W'(signed'(bus.instruction[15:0]));
    assign bus.md_start    = md_start_c && reset;
    assign bus.stall       = stall_c && reset;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_regfile_hilo_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_hilo_sb
// Purpose  : Self-checking bench: vector table, directed sequences, random vs model.
// Revision : 1.0
// ============================================================================
module tb_regfile_hilo_sb;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_hilo_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_hilo_sb #(.DATA_W(32), .REG_CNT(32), .ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
    } imm_vec_t;
    imm_vec_t tbl [7];

    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo;
    bit          m_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] v;
        v = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
        return v;
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [31:0] v;
        v = {op, 5'(rs), 5'(rt), imm};
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instruction = 32'd0;
        bus.instr_valid = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = 5'd0;
        bus.wr_data     = 32'd0;
        bus.md_done     = 1'b0;
        bus.md_hi       = 32'd0;
        bus.md_lo       = 32'd0;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = 5'(a); bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    localparam logic [5:0] MULT = 6'b011000, MFHI = 6'b010000, MTHI = 6'b010001;
    localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011, ADDU = 6'b100001;

    initial begin
        tbl[0] = '{it_i(6'b001101, 1, 2, 16'h8000), 32'h0000_8000};
        tbl[1] = '{it_i(6'b001000, 1, 2, 16'h8000), 32'hFFFF_8000};
        tbl[2] = '{it_i(6'b001100, 3, 4, 16'hFFFF), 32'h0000_FFFF};
        tbl[3] = '{it_i(6'b001110, 5, 6, 16'h8001), 32'h0000_8001};
        tbl[4] = '{it_i(6'b100011, 7, 8, 16'h7FFF), 32'h0000_7FFF};
        tbl[5] = '{32'h0000_8010,                   32'hFFFF_8010};
        tbl[6] = '{it_i(6'b001010, 0, 9, 16'hFFFE), 32'hFFFF_FFFE};

        idle_inputs();
        reset = 1'b0;
        #12;
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_stall", 32'(bus.stall), 0);
        chk("reset_md_start", 32'(bus.md_start), 0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();

        // Asynchronous reset in the middle of an outstanding multiply
        wb(5, 32'hAAAA);
        bus.instruction = rt_i(5, 5, 0, MULT); bus.instr_valid = 1'b1;
        #2; chk("pre_md_start", 32'(bus.md_start), 1);
        tick();
        bus.instruction = rt_i(0, 0, 4, MFLO);
        #2; chk("pre_busy_stall", 32'(bus.stall), 1);
        reset = 1'b0;
        #1;
        chk("async_stall", 32'(bus.stall), 0);
        chk("async_hi", bus.hi, 0);
        chk("async_lo", bus.lo, 0);
        bus.instruction = rt_i(5, 5, 0, ADDU);
        #1; chk("async_r5", bus.read_data_1, 0);
        tick();
        bus.instruction = rt_i(5, 5, 0, MULT);
        #1; chk("rst_md_start_low", 32'(bus.md_start), 0);
        bus.instruction = rt_i(0, 0, 4, MFLO);
        reset = 1'b1;
        #1; chk("post_rst_idle", 32'(bus.stall), 0);
        tick();
        bus.instr_valid = 1'b0;
        bus.md_done = 1'b1; bus.md_hi = 32'hDEAD; bus.md_lo = 32'hBEEF;
        tick();
        bus.md_done = 1'b0;
        #1; chk("idle_done_hi", bus.hi, 0);
        chk("idle_done_lo", bus.lo, 0);

        bus.instruction = rt_i(5, 5, 0, ADDU);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h1234;
        #2; chk("bypass_r5", bus.read_data_1, 32'h1234);
        chk("bypass_r5_rt", bus.read_data_2, 32'h1234);
        tick();
        bus.wr_en = 1'b0;
        #2; chk("array_r5", bus.read_data_1, 32'h1234);

        bus.instruction = rt_i(0, 0, 0, ADDU);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
        #2; chk("r0_bypass", bus.read_data_1, 0);
        tick();
        bus.wr_en = 1'b0;
        #2; chk("r0_array", bus.read_data_1, 0);

        foreach (tbl[i]) begin
            bus.instruction = tbl[i].instr;
            #1; chk($sformatf("imm_vec%0d", i), bus.imm_ext, tbl[i].imm);
        end
        tick();

        // mult issue, dependent mflo stalls until the cycle after md_done
        bus.instruction = rt_i(2, 3, 0, MULT); bus.instr_valid = 1'b1;
        #2; chk("mult_start", 32'(bus.md_start), 1);
        chk("mult_no_stall", 32'(bus.stall), 0);
        tick();
        bus.instruction = rt_i(0, 0, 10, MFLO);
        #2; chk("mflo_stall1", 32'(bus.stall), 1);
        chk("start_one_cycle", 32'(bus.md_start), 0);
        tick();
        #2; chk("mflo_stall2", 32'(bus.stall), 1);
        tick();
        bus.md_done = 1'b1; bus.md_hi = 32'hBEEF; bus.md_lo = 32'hCAFE;
        #2; chk("mflo_stall3", 32'(bus.stall), 1);
        tick();
        bus.md_done = 1'b0;
        #2; chk("mflo_go", 32'(bus.stall), 0);
        chk("md_lo", bus.lo, 32'hCAFE);
        chk("md_hi", bus.hi, 32'hBEEF);
        tick();
        bus.instr_valid = 1'b0; bus.instruction = rt_i(10, 0, 0, ADDU);
        #2; chk("mflo_r10", bus.read_data_1, 32'hCAFE);

        wb(3, 32'h77);
        bus.instruction = rt_i(3, 0, 0, MTHI); bus.instr_valid = 1'b1;
        tick();
        #1; chk("mthi_hi", bus.hi, 32'h77);
        bus.instruction = rt_i(0, 0, 8, MFHI);
        tick();
        bus.instruction = rt_i(0, 0, 0, MFHI);
        tick();
        bus.instr_valid = 1'b0; bus.instruction = rt_i(8, 0, 0, ADDU);
        #2; chk("mfhi_r8", bus.read_data_1, 32'h77);
        chk("mfhi_r0", bus.read_data_2, 0);

        bus.instruction = rt_i(7, 0, 0, MTLO); bus.instr_valid = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h22;
        tick();
        #1; chk("mtlo_fwd", bus.lo, 32'h22);
        bus.instruction = rt_i(0, 0, 9, MFLO);
        bus.wr_addr = 5'd9; bus.wr_data = 32'h11;
        tick();
        bus.instruction = rt_i(0, 0, 12, MFLO);
        bus.wr_addr = 5'd11; bus.wr_data = 32'h33;
        tick();
        bus.wr_en = 1'b0; bus.instr_valid = 1'b0;
        bus.instruction = rt_i(9, 11, 0, ADDU);
        #2; chk("conflict_r9", bus.read_data_1, 32'h22);
        chk("parallel_r11", bus.read_data_2, 32'h33);
        bus.instruction = rt_i(12, 0, 0, ADDU);
        #1; chk("parallel_r12", bus.read_data_1, 32'h22);
        tick();

        // Unrelated instruction while busy; md_done coinciding with a new MD op
        bus.instruction = rt_i(1, 2, 0, MULT); bus.instr_valid = 1'b1;
        tick();
        bus.instruction = rt_i(1, 2, 3, ADDU);
        #2; chk("busy_addu_stall", 32'(bus.stall), 0);
        tick();
        bus.instruction = rt_i(1, 2, 0, MULT);
        bus.md_done = 1'b1; bus.md_hi = 32'h1; bus.md_lo = 32'h2;
        #2; chk("done_op_stall", 32'(bus.stall), 1);
        chk("done_op_nostart", 32'(bus.md_start), 0);
        tick();
        bus.md_done = 1'b0;
        #2; chk("reissue_start", 32'(bus.md_start), 1);
        chk("reissue_hi", bus.hi, 32'h1);
        tick();
        bus.instr_valid = 1'b0;
        bus.md_done = 1'b1;
        tick();
        idle_inputs();

        // Randomised run against the reference model, from a fresh reset
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0;

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins, v1, v2, eimm, nhi, nlo;
            logic [4:0]  rs, rt, rd;
            logic [5:0]  op, fn;
            bit          isr, md, mfh, mfl, mth, mtl, e_stall, e_start;
            int          kind;
            kind = $urandom_range(0, 9);
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            case (kind)
                0: ins = rt_i(rs, rt, 0, 6'b0110_00 | 6'($urandom_range(0, 3)));
                1: ins = rt_i(0, 0, rd, MFHI);
                2: ins = rt_i(0, 0, rd, MFLO);
                3: ins = rt_i(rs, 0, 0, MTHI);
                4: ins = rt_i(rs, 0, 0, MTLO);
                5: ins = rt_i(rs, rt, rd, ADDU);
                6, 7: ins = it_i(6'($urandom_range(1, 63)), rs, rt, 16'($urandom));
                8: ins = $urandom;
                default: ins = rt_i(rs, rt, rd, 6'($urandom));
            endcase
            bus.instruction = ins;
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_en       = $urandom_range(0, 1);
            bus.wr_addr     = ($urandom_range(0, 3) == 0) ? ins[25:21] : 5'($urandom);
            bus.wr_data     = $urandom;
            bus.md_done     = m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
            bus.md_hi       = $urandom;
            bus.md_lo       = $urandom;

            op = ins[31:26]; fn = ins[5:0];
            rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            isr = (op == 0);
            md  = isr && (fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011});
            mfh = isr && fn == MFHI; mfl = isr && fn == MFLO;
            mth = isr && fn == MTHI; mtl = isr && fn == MTLO;
            v1 = (rs == 0) ? 0 : (bus.wr_en && bus.wr_addr == rs) ? bus.wr_data : m_regs[rs];
            v2 = (rt == 0) ? 0 : (bus.wr_en && bus.wr_addr == rt) ? bus.wr_data : m_regs[rt];
            eimm = (op inside {6'b001100, 6'b001101, 6'b001110}) ? {16'd0, ins[15:0]}
                                                                 : {{16{ins[15]}}, ins[15:0]};
            e_stall = m_busy && bus.instr_valid && (md || mfh || mfl || mth || mtl);
            e_start = !m_busy && bus.instr_valid && md;

            #2;
            chk("rnd_rd1", bus.read_data_1, v1);
            chk("rnd_rd2", bus.read_data_2, v2);
            chk("rnd_imm", bus.imm_ext, eimm);
            chk("rnd_start", 32'(bus.md_start), 32'(e_start));
            chk("rnd_stall", 32'(bus.stall), 32'(e_stall));
            chk("rnd_hi", bus.hi, m_hi);
            chk("rnd_lo", bus.lo, m_lo);

            nhi = m_hi; nlo = m_lo;
            if (bus.wr_en && bus.wr_addr != 0) m_regs[bus.wr_addr] = bus.wr_data;
            if (bus.instr_valid && !e_stall) begin
                if ((mfh || mfl) && rd != 0) m_regs[rd] = mfh ? m_hi : m_lo;
                if (mth) nhi = v1;
                if (mtl) nlo = v1;
            end
            if (m_busy && bus.md_done) begin
                nhi = bus.md_hi; nlo = bus.md_lo; m_busy = 1'b0;
            end
            if (e_start) m_busy = 1'b1;
            m_hi = nhi; m_lo = nlo;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
